// File: rtl/bus_arbiter_if.sv
// Peripheral bus bundle between two masters, the arbiter and the single slave.
// The arb modport is the arbiter's view; master/slave are the agents' views.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [STRB_W-1:0] m0_wstrb;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              m1_err;

  logic              s_valid;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;

  modport arb (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_rdata, m1_ack, m1_err,
    output s_valid, s_we, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_rdata, m1_ack, m1_err
  );

  modport slave (
    input  s_valid, s_we, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the SoC peripheral bus with a slave
// response watchdog. All bus outputs come straight from flops.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  bus_arbiter_if.arb bus
);
  // state  | meaning
  // IDLE   | sample requests, arbitrate, load s_* on a grant
  // ACCESS | s_* held stable, wait for s_ready or watchdog expiry
  // RESP   | one-cycle ack or err to the granted master

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic              ptr_q,      ptr_d;
  logic              gnt_q,      gnt_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              s_valid_q,  s_valid_d;
  logic              s_we_q,     s_we_d;
  logic [ADDR_W-1:0] s_addr_q,   s_addr_d;
  logic [DATA_W-1:0] s_wdata_q,  s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q,  s_wstrb_d;
  logic              m0_ack_q,   m0_ack_d;
  logic              m0_err_q,   m0_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic              m1_ack_q,   m1_ack_d;
  logic              m1_err_q,   m1_err_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              any_req;
  logic              gnt_sel;
  logic [DATA_W-1:0] rsp_data;

  // ptr_q == 1 means m1 wins a tie
  assign any_req  = bus.m0_req | bus.m1_req;
  assign gnt_sel  = bus.m1_req & (~bus.m0_req | ptr_q);
  assign rsp_data = s_we_q ? '0 : bus.s_rdata;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    s_valid_d  = s_valid_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m0_rdata_d = '0;
    m1_ack_d   = 1'b0;
    m1_err_d   = 1'b0;
    m1_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d     = gnt_sel;
          ptr_d     = ~gnt_sel;
          cnt_d     = '0;
          s_valid_d = 1'b1;
          s_we_d    = gnt_sel ? bus.m1_we    : bus.m0_we;
          s_addr_d  = gnt_sel ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d = gnt_sel ? bus.m1_wdata : bus.m0_wdata;
          s_wstrb_d = gnt_sel ? bus.m1_wstrb : bus.m0_wstrb;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        if (bus.s_ready) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (gnt_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = rsp_data;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = rsp_data;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (gnt_q) m1_err_d = 1'b1;
          else       m0_err_d = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      s_valid_q  <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      s_valid_q  <= s_valid_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus.s_valid  = s_valid_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wstrb  = s_wstrb_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m1_rdata = m1_rdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances share stimulus and differ
// only in TIMEOUT (0: 255, 1: 4, 2: disabled).
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [SW-1:0] m0_wstrb = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [SW-1:0] m1_wstrb = '0;
  logic          s_ready = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int TO = (g == 0) ? 255 : ((g == 1) ? 4 : 0);
    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
    assign bif.m0_req   = m0_req;
    assign bif.m0_we    = m0_we;
    assign bif.m0_addr  = m0_addr;
    assign bif.m0_wdata = m0_wdata;
    assign bif.m0_wstrb = m0_wstrb;
    assign bif.m1_req   = m1_req;
    assign bif.m1_we    = m1_we;
    assign bif.m1_addr  = m1_addr;
    assign bif.m1_wdata = m1_wdata;
    assign bif.m1_wstrb = m1_wstrb;
    assign bif.s_ready  = s_ready;
    assign bif.s_rdata  = s_rdata;
    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bif)
    );
  end

  wire          a_s_valid  = g_dut[0].bif.s_valid;
  wire          a_s_we     = g_dut[0].bif.s_we;
  wire [AW-1:0] a_s_addr   = g_dut[0].bif.s_addr;
  wire [DW-1:0] a_s_wdata  = g_dut[0].bif.s_wdata;
  wire [SW-1:0] a_s_wstrb  = g_dut[0].bif.s_wstrb;
  wire          a_m0_ack   = g_dut[0].bif.m0_ack;
  wire          a_m0_err   = g_dut[0].bif.m0_err;
  wire [DW-1:0] a_m0_rdata = g_dut[0].bif.m0_rdata;
  wire          a_m1_ack   = g_dut[0].bif.m1_ack;
  wire          a_m1_err   = g_dut[0].bif.m1_err;
  wire [DW-1:0] a_m1_rdata = g_dut[0].bif.m1_rdata;

  wire          b_s_valid  = g_dut[1].bif.s_valid;
  wire          b_m0_ack   = g_dut[1].bif.m0_ack;
  wire          b_m0_err   = g_dut[1].bif.m0_err;
  wire [DW-1:0] b_m0_rdata = g_dut[1].bif.m0_rdata;
  wire          b_m1_ack   = g_dut[1].bif.m1_ack;
  wire [DW-1:0] b_m1_rdata = g_dut[1].bif.m1_rdata;

  wire          c_s_valid  = g_dut[2].bif.s_valid;
  wire          c_m0_ack   = g_dut[2].bif.m0_ack;
  wire          c_m0_err   = g_dut[2].bif.m0_err;
  wire [DW-1:0] c_m0_rdata = g_dut[2].bif.m0_rdata;

  wire a_any = |{a_s_valid, a_s_we, a_s_addr, a_s_wdata, a_s_wstrb, a_m0_ack, a_m0_err,
                 a_m0_rdata, a_m1_ack, a_m1_err, a_m1_rdata};
  wire b_any = |{g_dut[1].bif.s_valid, g_dut[1].bif.s_we, g_dut[1].bif.s_addr,
                 g_dut[1].bif.s_wdata, g_dut[1].bif.s_wstrb, g_dut[1].bif.m0_ack,
                 g_dut[1].bif.m0_err, g_dut[1].bif.m0_rdata, g_dut[1].bif.m1_ack,
                 g_dut[1].bif.m1_err, g_dut[1].bif.m1_rdata};
  wire c_any = |{g_dut[2].bif.s_valid, g_dut[2].bif.s_we, g_dut[2].bif.s_addr,
                 g_dut[2].bif.s_wdata, g_dut[2].bif.s_wstrb, g_dut[2].bif.m0_ack,
                 g_dut[2].bif.m0_err, g_dut[2].bif.m0_rdata, g_dut[2].bif.m1_ack,
                 g_dut[2].bif.m1_err, g_dut[2].bif.m1_rdata};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
  endtask

  // Leaves reset released at a falling edge; the next rising edge is the first live one.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int first_err;
  int c_bad;

  initial begin
    // Reset state and a basic m0 read
    drive_idle();
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("reset_zero_a", a_any, 1'b0);
    check_eq("reset_zero_b", b_any, 1'b0);
    check_eq("reset_zero_c", c_any, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0004;
    @(negedge clk);
    check_eq("rd_s_valid", a_s_valid, 1'b1);
    check_eq("rd_s_addr", a_s_addr, 32'h1000_0004);
    check_eq("rd_s_we", a_s_we, 1'b0);
    check_eq("rd_no_ack_yet", a_m0_ack, 1'b0);
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("rd_m0_ack", a_m0_ack, 1'b1);
    check_eq("rd_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    check_eq("rd_m0_err", a_m0_err, 1'b0);
    check_eq("rd_s_valid_drop", a_s_valid, 1'b0);
    check_eq("rd_m1_quiet", {a_m1_ack, a_m1_err, a_m1_rdata}, '0);
    m0_req = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_ack_pulse", a_m0_ack, 1'b0);
    check_eq("rd_rdata_cleared", a_m0_rdata, '0);
    check_eq("rd_idle", a_s_valid, 1'b0);

    // Both masters requesting continuously from reset: alternate m0, m1
    drive_idle();
    m0_req = 1'b1; m0_addr = 32'h0000_00A0;
    m1_req = 1'b1; m1_addr = 32'h0000_00B0;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_eq("rr_m0_ack", a_m0_ack, (k == 2) || (k == 8));
      check_eq("rr_m1_ack", a_m1_ack, (k == 5) || (k == 11));
      check_eq("rr_s_valid", a_s_valid, (k % 3) == 1);
      if ((k % 3) == 1)
        check_eq("rr_s_addr", a_s_addr, ((k % 6) == 1) ? 32'h0000_00A0 : 32'h0000_00B0);
    end

    // m1 write with five wait cycles
    drive_idle();
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000_0000;
    m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
    s_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_eq("wr_s_fields", {a_s_valid, a_s_we, a_s_addr, a_s_wdata, a_s_wstrb},
               {1'b1, 1'b1, 32'h2000_0000, 32'h0000_00A5, 4'b0001});
      check_eq("wr_no_early_ack", a_m1_ack, 1'b0);
      if (k == 6) s_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("wr_m1_ack", a_m1_ack, 1'b1);
    check_eq("wr_m1_rdata", a_m1_rdata, '0);
    check_eq("wr_m0_quiet", {a_m0_ack, a_m0_err, a_m0_rdata}, '0);
    check_eq("wr_s_valid_drop", a_s_valid, 1'b0);
    m1_req = 1'b0; s_ready = 1'b0;
    @(negedge clk);

    // TIMEOUT=4 instance: slave never ready
    drive_idle();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0040;
    s_rdata = 32'h1111_2222;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("to_s_valid", b_s_valid, 1'b1);
      check_eq("to_no_err_yet", b_m0_err, 1'b0);
    end
    @(negedge clk);
    check_eq("to_s_valid_drop", b_s_valid, 1'b0);
    check_eq("to_m0_err", b_m0_err, 1'b1);
    check_eq("to_m0_ack", b_m0_ack, 1'b0);
    check_eq("to_m0_rdata", b_m0_rdata, '0);
    m0_req = 1'b0;
    @(negedge clk);
    check_eq("to_err_pulse", b_m0_err, 1'b0);
    m1_req = 1'b1; m1_addr = 32'h0000_0080;
    s_ready = 1'b1; s_rdata = 32'h0000_0055;
    @(negedge clk);
    check_eq("to_next_grant", b_s_valid, 1'b1);
    @(negedge clk);
    check_eq("to_next_ack", b_m1_ack, 1'b1);
    check_eq("to_next_rdata", b_m1_rdata, 32'h0000_0055);
    m1_req = 1'b0; s_ready = 1'b0;
    @(negedge clk);

    // Reset asserted during an m1 access
    drive_idle();
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h3000_0008;
    m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF;
    @(negedge clk);
    check_eq("ra_s_valid", a_s_valid, 1'b1);
    check_eq("ra_s_addr", a_s_addr, 32'h3000_0008);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ra_async_zero_a", a_any, 1'b0);
    check_eq("ra_async_zero_b", b_any, 1'b0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_00A0;
    s_ready = 1'b1; s_rdata = 32'h7777_0000;
    repeat (2) begin
      @(negedge clk);
      check_eq("ra_no_m1_resp", {a_m1_ack, a_m1_err}, 2'b00);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("ra_m0_first_valid", a_s_valid, 1'b1);
    check_eq("ra_m0_first_addr", a_s_addr, 32'h0000_00A0);
    @(negedge clk);
    check_eq("ra_m0_ack", a_m0_ack, 1'b1);
    check_eq("ra_m1_ack", a_m1_ack, 1'b0);
    check_eq("ra_m0_rdata", a_m0_rdata, 32'h7777_0000);
    drive_idle();
    @(negedge clk);

    // Slow slave (300 cycles): TIMEOUT=0 must not fire, TIMEOUT=255 must
    drive_idle();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0300;
    first_err = 0;
    c_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (c_m0_err || !c_s_valid || c_m0_ack) c_bad++;
      if (a_m0_err && (first_err == 0)) first_err = k;
      if (k == 300) begin
        s_ready = 1'b1; s_rdata = 32'h3000_0300;
      end
    end
    check_eq("slow_c_no_err", c_bad, 0);
    check_eq("slow_a_err_cycle", first_err, 256);
    @(negedge clk);
    check_eq("slow_c_ack", c_m0_ack, 1'b1);
    check_eq("slow_c_rdata", c_m0_rdata, 32'h3000_0300);
    check_eq("slow_c_err", c_m0_err, 1'b0);
    drive_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
